idct_transpose_buf: RTL and testbench
=====================================

# idct_transpose_buf

Parametrised ping-pong transpose buffer for the IDCT datapath. It accepts a row-major stream of signed coefficients and re-emits each block column-major, so the row pass and column pass of a 2-D IDCT can share one 1-D engine. Block size is selected per block by `mode`: 4×4, 8×8, or 16×16 up to `MAX_N`. Two banks let one block be written while the previous one is read, giving one beat per cycle on each side.

## Interface
- `DATA_W`, default 16: sample width, signed two's complement.
- `MAX_N`, default 8: largest supported block edge; legal values are 4, 8, 16. Each bank holds `MAX_N*MAX_N` samples.
- `clk` input 1: the single clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `mode` input 2: block size selector, sampled only on the first accepted beat of a block.
  - 0 selects N=4.
  - 1 selects N=8.
  - 2 selects N=16.
  - 3 is reserved.
- `in_valid` input 1: an input sample is present.
- `in_data` input DATA_W: the input sample, row-major.
- `in_ready` output 1: the buffer can accept a beat this cycle.
- `out_valid` output 1: `out_data` holds a valid sample.
- `out_data` output DATA_W: the output sample, column-major.
- `out_ready` input 1: the downstream consumer accepts the beat.
- `out_first` output 1: marks the first beat of an output block.
- `out_last` output 1: marks the last beat of an output block.
- `out_mode` output 2: the mode of the block currently being output.
- `err_mode` output 1: one-cycle pulse reporting an illegal mode.

## Operation
- Beat rules:
  - An input beat is accepted when `in_valid && in_ready`.
  - An output beat transfers when `out_valid && out_ready`.
- Write side states: `W_IDLE`, `W_FILL`.
  - In `W_IDLE`, the first accepted beat latches `mode` into the write bank's mode tag and is stored at index 0. The state moves to `W_FILL`.
  - In `W_FILL`, samples are stored row-major at address r*MAX_N+c. The column count wraps at N-1, then the row count increments.
  - On the N*N-th beat, the bank is marked full, the write bank pointer toggles, and the state returns to `W_IDLE`.
- Illegal mode: mode 3, or N > `MAX_N`, seen on a block's first beat.
  - The beat is accepted and discarded.
  - `err_mode` pulses on the next cycle.
  - No block is started and the state stays in `W_IDLE`.
- Read side states: `R_IDLE`, `R_LOAD`, `R_DRAIN`.
  - The read bank is read column-major: the row index is the inner loop and wraps at N-1.
  - Output order for sample (r,c) is c*N+r.
  - After the N*N-th output transfer, the bank is marked empty and the read pointer toggles.
- Flags and mode:
  - `out_first` is high on output index 0 and `out_last` on index N*N-1.
  - `out_mode` equals the bank's mode tag and is stable for the whole block.
- Full and empty:
  - `in_ready` = 0 only when the write bank is still full, meaning both banks hold unread data.
  - `out_valid` = 0 whenever no bank is full and the output register is empty.
- Simultaneous events:
  - A write completing a bank and a read emptying the other bank in the same cycle are both honoured, with no lost cycle.
  - A bank just freed by the reader is writable on the next cycle.
- Back-to-back blocks with different modes are legal. Each bank carries its own mode tag.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_data`=0, `out_first`=0, `out_last`=0, `out_mode`=0, `err_mode`=0.
  - Both banks are empty, both pointers are 0, and both FSMs are idle.
  - Bank contents are not cleared.
- Reset mid-block discards any partial write and any undrained read. The first cycle after `rst` falls behaves exactly like post-reset.
- Latency from the accepted final input beat (cycle t) to the first `out_valid`:
  - Read side: `R_LOAD` at t+1, `out_valid`=1 at t+2.
- Output register:
  - `out_data`, `out_first`, `out_last` and `out_mode` are registered.
  - They hold while `out_valid && !out_ready`.
  - The next address is fetched in the transfer cycle so that continuous draining runs without bubbles.
- Sustained throughput is 1 sample/cycle on both sides for any mode sequence, provided `out_ready`=1.
- `in_ready` falls in the cycle after the second bank fills. It rises in the cycle after the `out_last` transfer.

## Structure
- Package `idct_pkg` holds:
  - Mode constants `MODE_4X4=2'd0`, `MODE_8X8=2'd1`, `MODE_16X16=2'd2`.
  - The function `n_of_mode(mode)`, returning 4/8/16, or 0 for reserved.
  - `idx_w(MAX_N)` = clog2(MAX_N).
- Sub-module `idct_tbuf_bank` contains one bank:
  - a register array with a write port and a registered read port;
  - a full flag and a mode tag.
- It is instantiated twice. The top level holds both FSMs and the pointers.

## Test plan
- 4×4 identity order: mode=0, inputs 0..15 with `out_ready`=1.
  - Required output is 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15.
  - `out_first` is high on the first beat and `out_last` on the final beat (value 15).
  - First `out_valid` occurs 2 cycles after input 15.
- 8×8 back-to-back: three 8×8 blocks (MAX_N=8) with values k*64+i.
  - Output is continuous with no idle cycles between blocks.
  - Block 1 starts 0,8,16,…,56,1,…
- Mixed modes: a 4×4, an 8×8, then a 4×4.
  - `out_mode` reads 0,1,0 per block.
  - Each block is transposed with its own N, and no samples leak across blocks.
- Backpressure: `out_ready`=0 while two 4×4 blocks are written.
  - `in_ready`=0 after beat 32.
  - Releasing `out_ready` drains 32 beats in order, then `in_ready` rises.
- Illegal mode: mode=3, or mode=2 with MAX_N=8, on a first beat.
  - `err_mode` is a single-cycle pulse and the sample is dropped.
  - A following legal 4×4 block outputs correctly.
- Reset mid-operation: assert `rst` after 5 beats of a 4×4 block.
  - Outputs return to reset values.
  - The next full 4×4 block (16..31) transposes correctly.

Source files
------------

// File: rtl/idct_transpose_buf_pkg.sv
// idct_pkg: shared constants, state types and helpers for the IDCT
// transpose buffer.
//   MODE_*     : block size selector encodings carried on mode/out_mode
//   w_state_t  : write-side FSM states
//   r_state_t  : read-side FSM states
//   n_of_mode  : block edge for a mode (0 for the reserved encoding)
//   idx_w      : bits needed for one row/column index of a MAX_N block
package idct_pkg;

  localparam logic [1:0] MODE_4X4   = 2'd0;
  localparam logic [1:0] MODE_8X8   = 2'd1;
  localparam logic [1:0] MODE_16X16 = 2'd2;

  typedef enum logic {
    W_IDLE,
    W_FILL
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_LOAD,
    R_DRAIN
  } r_state_t;

  function automatic logic [4:0] n_of_mode(input logic [1:0] mode);
    case (mode)
      MODE_4X4:   return 5'd4;
      MODE_8X8:   return 5'd8;
      MODE_16X16: return 5'd16;
      default:    return 5'd0;
    endcase
  endfunction

  function automatic int idx_w(input int max_n);
    return $clog2(max_n);
  endfunction

endpackage

// File: rtl/idct_transpose_buf_bank.sv
// idct_tbuf_bank: one bank of the ping-pong transpose buffer.
//   wr_en/wr_addr/wr_data : write port into the sample array
//   rd_en/rd_addr/rd_data : registered read port; rd_data holds while rd_en=0
//   set_full/clr_full     : mark the bank as holding / no longer holding a block
//   tag_we/tag_in         : latch the mode of the block being written
//   full/tag              : current full flag and mode tag
module idct_tbuf_bank
  import idct_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int MAX_N  = 8,
  localparam int AW     = 2 * idx_w(MAX_N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              set_full,
  input  logic              clr_full,
  input  logic              tag_we,
  input  logic [1:0]        tag_in,
  output logic              full,
  output logic [1:0]        tag
);

  logic [DATA_W-1:0] mem [MAX_N*MAX_N];
  logic [DATA_W-1:0] rd_data_q;
  logic              full_q, full_d;
  logic [1:0]        tag_q, tag_d;

  // Sample storage is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register doubles as the output data register of the buffer,
  // so it is reset and only advances when a new address is fetched.
  always_ff @(posedge clk) begin
    if (rst)        rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem[rd_addr];
  end

  always_comb begin
    full_d = full_q;
    tag_d  = tag_q;
    if (set_full)      full_d = 1'b1;
    else if (clr_full) full_d = 1'b0;
    if (tag_we) tag_d = tag_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      tag_q  <= MODE_4X4;
    end else begin
      full_q <= full_d;
      tag_q  <= tag_d;
    end
  end

  assign rd_data = rd_data_q;
  assign full    = full_q;
  assign tag     = tag_q;

endmodule

// File: rtl/idct_transpose_buf.sv
// idct_transpose_buf: ping-pong buffer that takes row-major NxN blocks and
// re-emits them column-major (N = 4/8/16 per block, up to MAX_N).
//   in_valid/in_ready/in_data/mode : row-major input stream, mode taken on
//                                    the first beat of each block
//   out_valid/out_ready/out_data   : column-major output stream
//   out_first/out_last/out_mode    : block framing and the block's mode
//   err_mode                       : one-cycle pulse for an illegal mode
module idct_transpose_buf
  import idct_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int MAX_N  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last,
  output logic [1:0]        out_mode,
  output logic              err_mode
);

  localparam int IW = idx_w(MAX_N);
  localparam int AW = 2 * IW;

  logic [1:0]             bank_full;
  logic [1:0][1:0]        bank_tag;
  logic [1:0][DATA_W-1:0] bank_rd;

  // Write side
  w_state_t      w_state_q, w_state_d;
  logic          wptr_q, wptr_d;
  logic [IW-1:0] w_row_q, w_row_d, w_col_q, w_col_d, w_nm1_q, w_nm1_d;
  logic          err_mode_q, err_mode_d;
  logic          in_fire, mode_ok, wr_en, set_full, tag_we, wr_done;
  logic [AW-1:0] wr_addr;
  logic [4:0]    n_in;

  // Read side
  r_state_t      r_state_q, r_state_d;
  logic          rptr_q, rptr_d;
  logic [IW-1:0] r_row_q, r_row_d, r_col_q, r_col_d, r_nm1_q, r_nm1_d;
  logic          out_valid_q, out_valid_d, out_first_q, out_first_d;
  logic          out_last_q, out_last_d, out_sel_q, out_sel_d;
  logic [1:0]    out_mode_q, out_mode_d;
  logic          rd_en, rd_bank, clr_full, fetch0, start_bank;
  logic          avail_cur, avail_nxt;
  logic [AW-1:0] rd_addr;

  assign in_ready = ~bank_full[wptr_q];
  assign in_fire  = in_valid & in_ready;
  assign n_in     = n_of_mode(mode);
  assign mode_ok  = (n_in != 5'd0) && (32'(n_in) <= MAX_N);

  always_comb begin
    w_state_d  = w_state_q;
    wptr_d     = wptr_q;
    w_row_d    = w_row_q;
    w_col_d    = w_col_q;
    w_nm1_d    = w_nm1_q;
    err_mode_d = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    set_full   = 1'b0;
    tag_we     = 1'b0;
    wr_done    = 1'b0;
    if (in_fire) begin
      case (w_state_q)
        W_IDLE: begin
          if (mode_ok) begin
            wr_en     = 1'b1;
            tag_we    = 1'b1;
            w_nm1_d   = IW'(n_in - 5'd1);
            w_row_d   = '0;
            w_col_d   = IW'(1);
            w_state_d = W_FILL;
          end else begin
            err_mode_d = 1'b1;
          end
        end
        default: begin
          wr_en   = 1'b1;
          wr_addr = {w_row_q, w_col_q};
          if (w_col_q == w_nm1_q) begin
            w_col_d = '0;
            w_row_d = w_row_q + IW'(1);
            if (w_row_q == w_nm1_q) begin
              wr_done   = 1'b1;
              set_full  = 1'b1;
              wptr_d    = ~wptr_q;
              w_state_d = W_IDLE;
            end
          end else begin
            w_col_d = w_col_q + IW'(1);
          end
        end
      endcase
    end
  end

  // A bank completing this very cycle counts as available so the reader
  // can start (or chain into it) without waiting for the full flag.
  assign avail_cur = bank_full[rptr_q]  | (wr_done & (wptr_q == rptr_q));
  assign avail_nxt = bank_full[~rptr_q] | (wr_done & (wptr_q != rptr_q));

  always_comb begin
    r_state_d   = r_state_q;
    rptr_d      = rptr_q;
    r_row_d     = r_row_q;
    r_col_d     = r_col_q;
    r_nm1_d     = r_nm1_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    out_mode_d  = out_mode_q;
    out_sel_d   = out_sel_q;
    rd_en       = 1'b0;
    rd_bank     = rptr_q;
    rd_addr     = '0;
    clr_full    = 1'b0;
    fetch0      = 1'b0;
    start_bank  = rptr_q;
    case (r_state_q)
      R_IDLE: if (avail_cur) r_state_d = R_LOAD;
      R_LOAD: begin
        fetch0    = 1'b1;
        r_state_d = R_DRAIN;
      end
      default: begin
        if (out_ready) begin
          if (out_last_q) begin
            clr_full = 1'b1;
            rptr_d   = ~rptr_q;
            if (avail_nxt) begin
              fetch0     = 1'b1;
              start_bank = ~rptr_q;
            end else begin
              out_valid_d = 1'b0;
              out_first_d = 1'b0;
              out_last_d  = 1'b0;
              r_state_d   = R_IDLE;
            end
          end else begin
            // Fetch the next column-major sample; row is the inner loop.
            rd_en       = 1'b1;
            rd_addr     = {r_row_q, r_col_q};
            out_first_d = 1'b0;
            out_last_d  = (r_row_q == r_nm1_q) && (r_col_q == r_nm1_q);
            if (r_row_q == r_nm1_q) begin
              r_row_d = '0;
              r_col_d = r_col_q + IW'(1);
            end else begin
              r_row_d = r_row_q + IW'(1);
            end
          end
        end
      end
    endcase
    if (fetch0) begin
      rd_en       = 1'b1;
      rd_bank     = start_bank;
      rd_addr     = '0;
      out_valid_d = 1'b1;
      out_first_d = 1'b1;
      out_last_d  = 1'b0;
      out_sel_d   = start_bank;
      out_mode_d  = bank_tag[start_bank];
      r_nm1_d     = IW'(n_of_mode(bank_tag[start_bank]) - 5'd1);
      r_row_d     = IW'(1);
      r_col_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q   <= W_IDLE;
      wptr_q      <= 1'b0;
      w_row_q     <= '0;
      w_col_q     <= '0;
      w_nm1_q     <= '0;
      err_mode_q  <= 1'b0;
      r_state_q   <= R_IDLE;
      rptr_q      <= 1'b0;
      r_row_q     <= '0;
      r_col_q     <= '0;
      r_nm1_q     <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_mode_q  <= MODE_4X4;
      out_sel_q   <= 1'b0;
    end else begin
      w_state_q   <= w_state_d;
      wptr_q      <= wptr_d;
      w_row_q     <= w_row_d;
      w_col_q     <= w_col_d;
      w_nm1_q     <= w_nm1_d;
      err_mode_q  <= err_mode_d;
      r_state_q   <= r_state_d;
      rptr_q      <= rptr_d;
      r_row_q     <= r_row_d;
      r_col_q     <= r_col_d;
      r_nm1_q     <= r_nm1_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_mode_q  <= out_mode_d;
      out_sel_q   <= out_sel_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    idct_tbuf_bank #(
      .DATA_W(DATA_W),
      .MAX_N (MAX_N)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en && (wptr_q == 1'(gi))),
      .wr_addr (wr_addr),
      .wr_data (in_data),
      .rd_en   (rd_en && (rd_bank == 1'(gi))),
      .rd_addr (rd_addr),
      .rd_data (bank_rd[gi]),
      .set_full(set_full && (wptr_q == 1'(gi))),
      .clr_full(clr_full && (rptr_q == 1'(gi))),
      .tag_we  (tag_we && (wptr_q == 1'(gi))),
      .tag_in  (mode),
      .full    (bank_full[gi]),
      .tag     (bank_tag[gi])
    );
  end

  assign out_valid = out_valid_q;
  assign out_data  = bank_rd[out_sel_q];
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign out_mode  = out_mode_q;
  assign err_mode  = err_mode_q;

endmodule

// File: tb/tb_idct_transpose_buf.sv
// Scoreboard bench: input beats feed a transpose reference model that
// queues the expected column-major stream; a negedge monitor compares
// every output transfer and the err_mode pulse.
module tb_idct_transpose_buf;

  localparam int DATA_W = 16;
  localparam int MAX_N  = 8;

  logic              clk = 1'b0, rst = 1'b1;
  logic [1:0]        mode = 2'd0;
  logic              in_valid = 1'b0, out_ready = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready, out_valid, out_first, out_last, err_mode;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_mode;

  idct_transpose_buf #(.DATA_W(DATA_W), .MAX_N(MAX_N)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .out_first(out_first), .out_last(out_last),
    .out_mode(out_mode), .err_mode(err_mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic              f;
    logic              l;
    logic [1:0]        m;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              e;
  logic [DATA_W-1:0] blk[$];
  int                blk_n = 0;
  logic [1:0]        blk_m = 2'd0;
  bit                in_blk = 1'b0;
  bit                err_pending = 1'b0;
  int                tests = 0, fails = 0;
  int                cyc = 0, last_in_cyc = 0, last_lat = -1;
  bit                prev_valid = 1'b0, rec = 1'b0;
  int                xfer_cyc[$];
  int                rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int n_ref(input logic [1:0] m);
    case (m)
      2'd0:    return 4;
      2'd1:    return 8;
      2'd2:    return 16;
      default: return 0;
    endcase
  endfunction

  // Reference: collect a block row-major, then emit it column by column.
  task automatic model_accept(input logic [DATA_W-1:0] d, input logic [1:0] m);
    exp_t x;
    int   n;
    if (!in_blk) begin
      n = n_ref(m);
      if (n == 0 || n > MAX_N) begin
        err_pending = 1'b1;
        $display("[TB] in  %0d mode=%0d dropped", d, m);
        return;
      end
      in_blk = 1'b1;
      blk_n  = n;
      blk_m  = m;
      blk.delete();
    end
    blk.push_back(d);
    $display("[TB] in  %0d mode=%0d", d, blk_m);
    if (blk.size() == blk_n * blk_n) begin
      for (int c = 0; c < blk_n; c++) begin
        for (int r = 0; r < blk_n; r++) begin
          x.d = blk[r * blk_n + c];
          x.f = (c == 0) && (r == 0);
          x.l = (c == blk_n - 1) && (r == blk_n - 1);
          x.m = blk_m;
          exp_q.push_back(x);
        end
      end
      in_blk = 1'b0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [DATA_W-1:0] d, input logic [1:0] m);
    int w = 0;
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    @(negedge clk);
    while (!in_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL in_ready_timeout: got 0 after %0d cycles, required 1", w);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_accept(d, m);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_block(input logic [1:0] m, input int base, input bit rnd_data,
                            input bit gaps);
    int n = n_ref(m);
    for (int i = 0; i < n * n; i++) begin
      send(rnd_data ? DATA_W'($urandom) : DATA_W'(base + i), m);
      if (gaps && $urandom_range(0, 3) == 0) idle(1);
    end
  endtask

  task automatic wait_drain(input string name);
    int w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < 5000) begin
      @(posedge clk);
      #1;
      w++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  in_ready,  1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_out_first"}, out_first, 0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_out_mode"},  out_mode,  0);
    check({tag, "_err_mode"},  err_mode,  0);
  endtask

  // Called at posedge+1; leaves at posedge+1 with rst low.
  task automatic do_reset(input string tag);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals({tag, "_during"});
    exp_q.delete();
    blk.delete();
    in_blk      = 1'b0;
    err_pending = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals({tag, "_after"});
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (in_valid && in_ready) last_in_cyc = cyc;
      if (out_valid && !prev_valid) last_lat = cyc - last_in_cyc;
      prev_valid = out_valid;
      if (err_mode || err_pending) check("err_mode", err_mode, err_pending);
      err_pending = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL extra_out: got data %0d, required no beat", out_data);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] out %0d f=%0d l=%0d m=%0d", out_data, out_first, out_last, out_mode);
          check("out_data",  out_data,  e.d);
          check("out_first", out_first, e.f);
          check("out_last",  out_last,  e.l);
          check("out_mode",  out_mode,  e.m);
          if (rec) xfer_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset("rst0");

    // 4x4 identity order and load latency
    send_block(2'd0, 0, 1'b0, 1'b0);
    wait_drain("t4x4_drain");
    check("t4x4_latency", last_lat, 2);

    // Three back-to-back 8x8 blocks must drain without bubbles
    xfer_cyc.delete();
    rec = 1'b1;
    for (int k = 0; k < 3; k++) send_block(2'd1, k * 64, 1'b0, 1'b0);
    wait_drain("b2b_drain");
    rec = 1'b0;
    check("b2b_count", xfer_cyc.size(), 192);
    if (xfer_cyc.size() == 192) check("b2b_span", xfer_cyc[191] - xfer_cyc[0], 191);

    // Mixed modes with random gaps and random backpressure
    rdy_mode = 1;
    send_block(2'd0, 0, 1'b1, 1'b1);
    send_block(2'd1, 0, 1'b1, 1'b1);
    send_block(2'd0, 0, 1'b1, 1'b1);
    wait_drain("mixed_drain");

    // Backpressure: both banks fill, writer stalls until the reader frees one
    rdy_mode = 2;
    idle(2);
    send_block(2'd0, 300, 1'b0, 1'b0);
    send_block(2'd0, 316, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    idle(3);
    check("bp_in_ready_held", in_ready, 0);
    rdy_mode = 0;
    wait_drain("bp_drain");
    check("bp_in_ready_high", in_ready, 1);

    // Illegal modes are dropped with a pulse, then a legal block follows
    send(DATA_W'(100), 2'd3);
    idle(2);
    send(DATA_W'(101), 2'd2);
    send_block(2'd0, 200, 1'b0, 1'b0);
    wait_drain("illegal_drain");

    // Reset in the middle of a block
    for (int i = 0; i < 5; i++) send(DATA_W'(50 + i), 2'd0);
    do_reset("rst_mid");
    send_block(2'd0, 16, 1'b0, 1'b0);
    wait_drain("rst_mid_drain");

    // Random mix including illegal first beats
    rdy_mode = 1;
    for (int b = 0; b < 10; b++) begin
      int r = $urandom_range(0, 9);
      if (r == 8)      send(DATA_W'($urandom), 2'd3);
      else if (r == 9) send(DATA_W'($urandom), 2'd2);
      send_block((r < 5) ? 2'd0 : 2'd1, 0, 1'b1, 1'b1);
    end
    wait_drain("rand_drain");
    rdy_mode = 0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
